// File: rtl/uart_tx_fifo_pkg.sv
// Shared defaults and sizing helper for the UART transmit FIFO and its storage array.
package uart_tx_fifo_pkg;

  localparam int unsigned DefaultDepth       = 8;
  localparam int unsigned DefaultPayloadBits = 8;

  // Level must represent 0..depth inclusive, hence one bit more than the pointers.
  function automatic int unsigned levelWidth(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// DEPTH x PAYLOAD_BITS register array: one synchronous write port, one asynchronous read port.
module uart_tx_fifo_mem
  import uart_tx_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH        = DefaultDepth,
  parameter  int unsigned PAYLOAD_BITS = DefaultPayloadBits,
  localparam int unsigned PTR_W        = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    wrEn_i,
  input  logic [PTR_W-1:0]        wrAddr_i,
  input  logic [PAYLOAD_BITS-1:0] wrData_i,
  input  logic [PTR_W-1:0]        rdAddr_i,
  output logic [PAYLOAD_BITS-1:0] rdData_o
);

  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];

  // Contents are deliberately left unreset; the head is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer feeding the UART transmitter through its en/busy handshake,
// with level, full/empty, low-water interrupt and sticky overflow reporting.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH        = DefaultDepth,
  parameter  int unsigned PAYLOAD_BITS = DefaultPayloadBits,
  localparam int unsigned LEVEL_W      = levelWidth(DEPTH),
  localparam int unsigned PTR_W        = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_en,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  input  logic                    flush,
  input  logic                    tx_hold,
  input  logic [LEVEL_W-1:0]      thresh,
  input  logic                    ovf_clear,
  output logic [LEVEL_W-1:0]      level,
  output logic                    full,
  output logic                    empty,
  output logic                    irq_low,
  output logic                    overflow,
  output logic                    uart_tx_en,
  output logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_tx_busy
);

  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               overflow_q;
  logic               irqLow_q;
  logic               push;
  logic               pop;
  logic               ovfSet;

  assign full  = (level_q == LEVEL_W'(DEPTH));
  assign empty = (level_q == '0);

  // Full is judged on the current level, so a same-cycle pop never frees room for a write.
  assign push   = wr_en && !full && !flush;
  assign ovfSet = wr_en && full && !flush;
  assign pop    = uart_tx_en;

  assign uart_tx_en = !empty && !uart_tx_busy && !tx_hold && !flush;

  uart_tx_fifo_mem #(
    .DEPTH        (DEPTH),
    .PAYLOAD_BITS (PAYLOAD_BITS)
  ) uMem (
    .clk      (clk),
    .wrEn_i   (push),
    .wrAddr_i (wrPtr_q),
    .wrData_i (wr_data),
    .rdAddr_i (rdPtr_q),
    .rdData_o (uart_tx_data)
  );

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      level_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      if (push && !pop)      level_d = level_q + LEVEL_W'(1);
      else if (!push && pop) level_d = level_q - LEVEL_W'(1);
    end
  end

  // A dropped write and a clear in the same cycle leave overflow set.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      irqLow_q   <= 1'b1;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      level_q  <= level_d;
      irqLow_q <= (level_d <= thresh);
      if (ovfSet)         overflow_q <= 1'b1;
      else if (ovf_clear) overflow_q <= 1'b0;
    end
  end

  assign level    = level_q;
  assign overflow = overflow_q;
  assign irq_low  = irqLow_q;

endmodule
